// File: rtl/stream_xbar_arb_if.sv
// Handshake bundle between the slave streams, the master-side ready and the arbiter.
// Combinational signals only; timing is set by whoever drives and samples it.
// Arbiter sits on the slave modport; the stream environment drives the master modport.
interface stream_xbar_arb_if #(
  parameter int S_DATA_COUNT = 2,
  parameter int M_DATA_COUNT = 3,
  parameter int T_DEST_WIDTH = $clog2(M_DATA_COUNT)
);
  logic [S_DATA_COUNT-1:0]                   s_valid_i;
  logic [S_DATA_COUNT-1:0]                   s_last_i;
  logic [S_DATA_COUNT-1:0][T_DEST_WIDTH-1:0] s_dest_i;
  logic [M_DATA_COUNT-1:0]                   m_ready_i;
  logic [M_DATA_COUNT-1:0][S_DATA_COUNT-1:0] grant_o;
  logic [S_DATA_COUNT-1:0]                   s_ready_o;

  modport master (
    output s_valid_i, s_last_i, s_dest_i, m_ready_i,
    input  grant_o, s_ready_o
  );

  modport slave (
    input  s_valid_i, s_last_i, s_dest_i, m_ready_i,
    output grant_o, s_ready_o
  );
endinterface

// File: rtl/stream_xbar_arb.sv
// Per-output round-robin packet arbiter driving the crossbar grant matrix and slave ready.
// Latency: request to grant 1 cycle; one idle bubble per packet boundary per master.
// Backpressure: s_ready_o is the registered grant gated by m_ready_i; grant held until last.
// Optional watchdog release of stalled packets: define STREAM_XBAR_ARB_WDOG_EN.
module stream_xbar_arb #(
  parameter int S_DATA_COUNT = 2,
  parameter int M_DATA_COUNT = 3,
  parameter int T_DEST_WIDTH = $clog2(M_DATA_COUNT),
  parameter int WDOG_CYCLES  = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  stream_xbar_arb_if.slave bus
`ifdef STREAM_XBAR_ARB_WDOG_EN
  ,
  output logic [M_DATA_COUNT-1:0] wdog_err_o
`endif
);

  localparam int PW = (S_DATA_COUNT > 1) ? $clog2(S_DATA_COUNT) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t state_q [M_DATA_COUNT];
  state_t state_d [M_DATA_COUNT];

  logic [M_DATA_COUNT-1:0][S_DATA_COUNT-1:0] gnt_q, gnt_d, req;
  logic [M_DATA_COUNT-1:0][PW-1:0]           ptr_q, ptr_d;
  logic [S_DATA_COUNT-1:0][T_DEST_WIDTH-1:0] dest;
  logic [S_DATA_COUNT-1:0]                   locked, ready;

`ifdef STREAM_XBAR_ARB_WDOG_EN
  localparam int CW = $clog2(WDOG_CYCLES + 1);
  logic [M_DATA_COUNT-1:0][CW-1:0] cnt_q, cnt_d;
  logic [M_DATA_COUNT-1:0]         err_q, err_d;
  assign wdog_err_o = err_q;
`endif

  if (WDOG_CYCLES < 1) begin : g_bad_wdog
    $error("stream_xbar_arb: WDOG_CYCLES must be at least 1");
  end

  assign dest          = bus.s_dest_i;
  assign bus.grant_o   = gnt_q;
  assign bus.s_ready_o = ready;

  // Requests: a valid beat aimed at this master from a slave not already locked by any master.
  always_comb begin
    locked = '0;
    for (int m = 0; m < M_DATA_COUNT; m++) locked = locked | gnt_q[m];
    req = '0;
    for (int m = 0; m < M_DATA_COUNT; m++) begin
      for (int s = 0; s < S_DATA_COUNT; s++) begin
        req[m][s] = bus.s_valid_i[s] && !locked[s] && (int'(dest[s]) == m);
      end
    end
  end

  // Slave ready: registered grant gated by the owning master's ready.
  always_comb begin
    ready = '0;
    for (int m = 0; m < M_DATA_COUNT; m++) begin
      ready = ready | (gnt_q[m] & {S_DATA_COUNT{bus.m_ready_i[m]}});
    end
  end

  // Per-master next state: round-robin pick in IDLE, release on last (or watchdog) in BUSY.
  always_comb begin
    int   pick;
    int   cur;
    logic found;
    logic hs_last;
    logic rel;
`ifdef STREAM_XBAR_ARB_WDOG_EN
    logic hs;
    hs    = 1'b0;
    cnt_d = cnt_q;
    err_d = '0;
`endif
    pick    = 0;
    cur     = 0;
    found   = 1'b0;
    hs_last = 1'b0;
    rel     = 1'b0;
    for (int m = 0; m < M_DATA_COUNT; m++) begin
      state_d[m] = state_q[m];
      gnt_d[m]   = gnt_q[m];
      ptr_d[m]   = ptr_q[m];
      found      = 1'b0;
      rel        = 1'b0;
      cur        = 0;
      hs_last    = bus.m_ready_i[m] && |(gnt_q[m] & bus.s_valid_i & bus.s_last_i);
`ifdef STREAM_XBAR_ARB_WDOG_EN
      hs         = bus.m_ready_i[m] && |(gnt_q[m] & bus.s_valid_i);
`endif
      for (int s = 0; s < S_DATA_COUNT; s++) begin
        if (gnt_q[m][s]) cur = s;
      end
      case (state_q[m])
        IDLE: begin
          for (int k = 0; k < S_DATA_COUNT; k++) begin
            pick = (int'(ptr_q[m]) + k) % S_DATA_COUNT;
            if (!found && req[m][pick]) begin
              found = 1'b1;
              cur   = pick;
            end
          end
          if (found) begin
            gnt_d[m]   = S_DATA_COUNT'(1) << cur;
            state_d[m] = BUSY;
          end
`ifdef STREAM_XBAR_ARB_WDOG_EN
          cnt_d[m] = '0;
`endif
        end
        BUSY: begin
          rel = hs_last;
`ifdef STREAM_XBAR_ARB_WDOG_EN
          // Counter holds the number of stalled BUSY cycles already seen.
          if (hs) begin
            cnt_d[m] = '0;
          end else if (cnt_q[m] == CW'(WDOG_CYCLES - 1)) begin
            rel      = 1'b1;
            err_d[m] = 1'b1;
            cnt_d[m] = '0;
          end else begin
            cnt_d[m] = cnt_q[m] + CW'(1);
          end
`endif
          if (rel) begin
            gnt_d[m]   = '0;
            ptr_d[m]   = (cur == S_DATA_COUNT - 1) ? '0 : PW'(cur + 1);
            state_d[m] = IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  // State, grant and pointer registers; synchronous reset returns every master to IDLE.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int m = 0; m < M_DATA_COUNT; m++) state_q[m] <= IDLE;
      gnt_q <= '0;
      ptr_q <= '0;
`ifdef STREAM_XBAR_ARB_WDOG_EN
      cnt_q <= '0;
      err_q <= '0;
`endif
    end else begin
      for (int m = 0; m < M_DATA_COUNT; m++) state_q[m] <= state_d[m];
      gnt_q <= gnt_d;
      ptr_q <= ptr_d;
`ifdef STREAM_XBAR_ARB_WDOG_EN
      cnt_q <= cnt_d;
      err_q <= err_d;
`endif
    end
  end

endmodule
